// File: rtl/cheri_dmem_responder.sv
// Tagged data-memory responder: 32-bit words plus a capability tag per word,
// answering granted requests in order after a programmable latency.
module cheri_dmem_responder #(
  parameter int          DataWidth = 33,
  parameter logic [31:0] AddrBase  = 32'h2000_0000,
  parameter int          MemWords  = 1024,
  parameter int          MaxOutst  = 2,
  parameter int          RespLat   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_req_i,
  input  logic                 data_is_cap_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 data_err_o,
  input  logic                 stall_i,
  output logic                 busy_o
);

  localparam int          AW       = $clog2(MemWords);
  localparam logic [31:0] SPAN     = 32'(4 * MemWords);
  localparam logic [2:0]  MAX_CNT  = 3'(MaxOutst);
  localparam logic [1:0]  PTR_LAST = 2'(MaxOutst - 1);
  localparam logic [1:0]  LAT_INIT = 2'(RespLat - 1);

  logic [31:0]          mem_q [MemWords];
  logic [MemWords-1:0]  tag_q, tag_d;

  logic [DataWidth-1:0] fifo_rdata_q [4];
  logic [3:0]           fifo_err_q;
  logic [1:0]           head_q, head_d, tail_q, tail_d, lat_q, lat_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 rvalid_q, rvalid_d, err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic [31:0]          off, rd_word, wmask, wr_word;
  logic [AW-1:0]        idx;
  logic                 req_err, rd_tag, gnt, pop, mem_wr;
  logic [DataWidth-1:0] push_rdata;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    off     = data_addr_i - AddrBase;
    idx     = off[AW+1:2];
    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    req_err = (off >= SPAN) || (data_addr_i[1:0] != 2'b00) ||
              (data_is_cap_i && (data_be_i != 4'hF));
    rd_word = mem_q[idx];
    rd_tag  = tag_q[idx];
    wmask   = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    wr_word = (rd_word & ~wmask) | (data_wdata_i[31:0] & wmask);

    pop = (cnt_q != 3'd0) && (lat_q == 2'd0);
    gnt = data_req_i && !stall_i && !rst_i && ((cnt_q < MAX_CNT) || pop);
    mem_wr = gnt && data_we_i && !req_err;

    // Non-cap stores always drop the tag, even with no bytes enabled.
    tag_d = tag_q;
    if (mem_wr) tag_d[idx] = data_is_cap_i & data_wdata_i[32];

    if (req_err || data_we_i) push_rdata = '0;
    else                      push_rdata = {data_is_cap_i & rd_tag, rd_word};

    cnt_d  = cnt_q + 3'(gnt) - 3'(pop);
    head_d = pop ? ptr_inc(head_q) : head_q;
    tail_d = gnt ? ptr_inc(tail_q) : tail_q;

    lat_d = lat_q;
    if (pop || (gnt && (cnt_q == 3'd0))) lat_d = LAT_INIT;
    else if (cnt_q != 3'd0)              lat_d = lat_q - 2'd1;

    rvalid_d = pop;
    rdata_d  = pop ? fifo_rdata_q[head_q] : rdata_q;
    err_d    = pop ? fifo_err_q[head_q]   : err_q;
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[idx] <= wr_word;
    if (gnt) fifo_rdata_q[tail_q] <= push_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q      <= '0;
      fifo_err_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      if (gnt) fifo_err_q[tail_q] <= req_err;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign busy_o        = (cnt_q != 3'd0);

endmodule

// File: doc/cheri_dmem_responder.md
Name: cheri_dmem_responder

Overview:
- Memory-side responder for the core's data memory interface (req/gnt/rvalid, we, be, addr, wdata, is_cap, err).
- Implements a tagged word memory: 32-bit data plus one capability-tag bit per word.
- Supports in-order pipelined responses with programmable latency and a bounded number of outstanding transactions.
- Used as the data-side memory model in simulation and FPGA builds.

Parameters:
- DataWidth, 33, bus data width; 33 means bit 32 is the tag (only 33 is supported).
- AddrBase, 32'h2000_0000, byte address of word 0.
- MemWords, 1024, number of 32-bit words (power of 2).
- MaxOutst, 2, response FIFO depth (1..4).
- RespLat, 1, cycles from grant to rvalid for an uncontended request (1..4).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- data_req_i  in  1  request valid
- data_is_cap_i  in  1  capability (tagged) access
- data_we_i  in  1  1=store, 0=load
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  DataWidth  store data; bit 32 is the tag
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response valid, one cycle per accepted request
- data_rdata_o  out  DataWidth  load data; bit 32 is the tag
- data_err_o  out  1  response error, qualified by rvalid
- stall_i  in  1  test hook; forces gnt low
- busy_o  out  1  FIFO non-empty

Behaviour:
- Reset (rst_i high, async): gnt=0, rvalid=0, rdata=0, err=0, busy=0. FIFO is emptied and the latency counter is cleared. All tags are cleared to 0; data words are not reset.
- Reset mid-operation: all pending responses are dropped and no rvalid is produced for them. After reset deasserts, gnt may assert in the first cycle.
- Grant is combinational: gnt = req & ~stall_i & (count<MaxOutst | pop_this_cycle).
- Memory access happens in the grant cycle:
  - Stores update the array at the clock edge.
  - Loads capture data into the FIFO entry at the same edge.
  - A load granted the cycle after a store to the same word returns the new data.
- Error conditions, any one of:
  - addr outside [AddrBase, AddrBase+4*MemWords)
  - addr[1:0]!=0
  - is_cap=1 with be!=4'hF
  - On error: no array write, the entry carries err=1 and rdata=0.
- Store, is_cap=1: the word gets wdata[31:0] and tag=wdata[32].
- Store, is_cap=0: byte-enable merge into data[31:0]; the word's tag is cleared to 0 regardless of be (be=0 still clears the tag).
- Load, is_cap=1: rdata = {tag, data}.
- Load, is_cap=0: rdata = {1'b0, data}.
- Store responses: rdata=0.
- Response FIFO: in-order, depth MaxOutst. Each entry holds rdata and err.
- Latency counter on the FIFO head:
  - When an entry becomes head, the counter loads RespLat-1.
  - For a grant into an empty FIFO, rvalid asserts RespLat cycles after the grant edge.
  - When the counter reaches 0 with the FIFO non-empty: rvalid=1 for exactly one cycle, rdata/err driven from the head, head popped.
  - The next head reloads the counter the same cycle, so back-to-back throughput is 1 per RespLat cycles.
- rvalid has no backpressure. Outputs are registered; rdata and err hold their last value when rvalid=0.
- Full FIFO: gnt=0 unless a pop occurs the same cycle. Push and pop in the same cycle leaves count unchanged.
- busy_o = (count!=0).

Test Plan:
- Reset, then store is_cap=1 to addr AddrBase+8 with wdata=33'h1_DEADBEEF, then load is_cap=1 from the same addr -> gnt same cycle as req; load response rvalid with rdata=33'h1_DEADBEEF, err=0; each rvalid occurs RespLat cycles after its grant.
- After the previous step, store is_cap=0 with be=4'b0011, wdata=32'h0000_1234, then load is_cap=1 -> rdata=33'h0_DEAD1234 (tag cleared, bytes merged).
- Load from AddrBase+4*MemWords, then from AddrBase+2, then is_cap load with be=4'h3 -> three responses, each err=1, rdata=0; memory unchanged.
- RespLat=3, MaxOutst=2, req held high for 6 loads -> gnt pattern limits outstanding to 2; exactly one rvalid every 3 cycles; 6 rvalids in order.
- Reset asserted with 2 responses pending -> rvalid=0 and busy_o=0 immediately; no stale rvalid after release; a load of a previously tagged word returns tag=0.
- stall_i=1 for 4 cycles with req high -> gnt=0 throughout; the request is granted in the first cycle after stall_i drops.
